// File: rtl/rc4_sbox_engine_pkg.sv
// Shared types and constants for the RC4 S-box control engine and its bench.
package rc4_pkg;
   localparam int BYTE_W           = 8;
   localparam int SBOX_DEPTH       = 256;
   localparam int KSA_CYCLES       = 512;
   localparam int PRGA_STEP_CYCLES = 3;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      KSA_RD,
      KSA_SW,
      PR_RD,
      PR_SW,
      PR_OUT
   } state_t;
endpackage

// File: rtl/rc4_sbox_engine_if.sv
// S-box RAM bus plus keystream valid/ready channel; master is the engine.
interface rc4_sbox_engine_if;
   import rc4_pkg::*;

   byte_t ks_data;
   logic  ks_valid;
   logic  ks_ready;
   logic  sbox_rst_n;
   logic  sbox_wen;
   byte_t raddr_1;
   byte_t rdata_1;
   byte_t waddr_2;
   byte_t wdata_2;
   byte_t addr_3;
   byte_t wdata_3;
   byte_t rdata_3;

   modport master (
      output ks_data, ks_valid, sbox_rst_n, sbox_wen,
      output raddr_1, waddr_2, wdata_2, addr_3, wdata_3,
      input  ks_ready, rdata_1, rdata_3
   );

   modport slave (
      input  ks_data, ks_valid, sbox_rst_n, sbox_wen,
      input  raddr_1, waddr_2, wdata_2, addr_3, wdata_3,
      output ks_ready, rdata_1, rdata_3
   );
endinterface

// File: rtl/rc4_sbox_engine_outreg.sv
// One-entry keystream output register; holds data/valid stable until accepted.
module rc4_ks_outreg
   import rc4_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  logic  load,
   input  byte_t din,
   input  logic  ready,
   output byte_t data,
   output logic  valid,
   output logic  can_load
);
   assign can_load = !valid || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load && can_load) begin
         data  <= din;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/rc4_sbox_engine.sv
// RC4 control engine: sequences KSA then PRGA over an external 3-port S-box RAM.
module rc4_sbox_engine
   import rc4_pkg::*;
#(
   parameter int KEY_MAX = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [8*KEY_MAX-1:0]   key,
   input  logic [4:0]             key_len,
   output logic                   busy,
   rc4_sbox_engine_if.master      bus
);
   localparam int KI = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

   state_t        state, state_n;
   byte_t         i, j, t, si_q;
   logic [KI-1:0] kidx, last_idx;
   byte_t         key_b [KEY_MAX];
   logic          key_ok, accept, cap, can_load;
   logic          sbox_rst_n, sbox_wen;
   byte_t         raddr_1, waddr_2, wdata_2, addr_3, wdata_3;
   byte_t         ks_data;
   logic          ks_valid;

   assign key_ok = (key_len != 5'd0) && (int'(key_len) <= KEY_MAX);
   assign accept = (state == IDLE) && start && !stop && key_ok;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      sbox_rst_n = 1'b1;
      sbox_wen   = 1'b0;
      raddr_1    = '0;
      waddr_2    = '0;
      wdata_2    = '0;
      addr_3     = '0;
      wdata_3    = '0;
      cap        = 1'b0;
      case (state)
         IDLE:   if (accept) state_n = INIT;
         INIT: begin
            sbox_rst_n = 1'b0;
            state_n    = KSA_RD;
         end
         KSA_RD: begin
            raddr_1 = i;
            state_n = KSA_SW;
         end
         // Swap S[i] <-> S[j]: port 2 writes S[j] into i, port 3 writes old S[i] into j
         KSA_SW, PR_SW: begin
            addr_3   = j;
            waddr_2  = i;
            wdata_2  = bus.rdata_3;
            wdata_3  = si_q;
            sbox_wen = 1'b1;
            if (state == PR_SW)              state_n = PR_OUT;
            else if (i == byte_t'(SBOX_DEPTH-1)) state_n = PR_RD;
            else                             state_n = KSA_RD;
         end
         PR_RD: begin
            raddr_1 = i + 8'd1;
            state_n = PR_SW;
         end
         PR_OUT: begin
            raddr_1 = t;
            if (can_load) begin
               cap     = 1'b1;
               state_n = PR_RD;
            end
         end
         default: state_n = IDLE;
      endcase
      if (stop) state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (accept)
         for (int n = 0; n < KEY_MAX; n++) key_b[n] <= key[8*n +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i        <= '0;
         j        <= '0;
         t        <= '0;
         si_q     <= '0;
         kidx     <= '0;
         last_idx <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               i        <= '0;
               j        <= '0;
               kidx     <= '0;
               last_idx <= KI'(key_len - 5'd1);
            end
            KSA_RD: begin
               si_q <= bus.rdata_1;
               j    <= j + bus.rdata_1 + key_b[kidx];
            end
            KSA_SW: begin
               kidx <= (kidx == last_idx) ? '0 : kidx + KI'(1);
               if (i == byte_t'(SBOX_DEPTH-1)) begin
                  i <= '0;
                  j <= '0;
               end else begin
                  i <= i + 8'd1;
               end
            end
            PR_RD: begin
               i    <= i + 8'd1;
               si_q <= bus.rdata_1;
               j    <= j + bus.rdata_1;
            end
            PR_SW:   t <= si_q + bus.rdata_3;
            default: ;
         endcase
      end
   end

   rc4_ks_outreg u_outreg (
      .clk      (clk),
      .rst      (rst),
      .flush    (stop),
      .load     (cap),
      .din      (bus.rdata_1),
      .ready    (bus.ks_ready),
      .data     (ks_data),
      .valid    (ks_valid),
      .can_load (can_load)
   );

   assign bus.ks_data    = ks_data;
   assign bus.ks_valid   = ks_valid;
   assign bus.sbox_rst_n = sbox_rst_n;
   assign bus.sbox_wen   = sbox_wen;
   assign bus.raddr_1    = raddr_1;
   assign bus.waddr_2    = waddr_2;
   assign bus.wdata_2    = wdata_2;
   assign bus.addr_3     = addr_3;
   assign bus.wdata_3    = wdata_3;
endmodule
